// File: rtl/scc_pkg.sv
// Shared widths, NOP encoding and FSM state encoding for the IF/ID buffer.
package scc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = INSTR_W + PC_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH-entry register FIFO holding {pc, instr}; reset is asynchronous active-low.
module if_id_fifo_mem
  import scc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [ENTRY_W-1:0]             wr_data,
  output logic [ENTRY_W-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_rd;

  // A write into a full FIFO or a read from an empty one is silently dropped.
  assign do_wr = wr_en & (count != FULL);
  assign do_rd = rd_en & (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID skid FIFO with flush and prefetch-shadow drop; reset is asynchronous active-low.
// Define IF_ID_PERF_EN to add saturating stall_cycles / flushed_words counters.
module if_id_buffer
  import scc_pkg::*;
#(
  parameter int                 DEPTH    = 2,
  parameter int                 SHADOW   = 1,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flushed_words
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL        = CW'(DEPTH);
  localparam logic [1:0]    SHADOW_LOAD = 2'(SHADOW);

  state_t      state, state_next;
  logic [1:0]  shadow_cnt, shadow_next;
  logic        push, pop;
  logic        store, take;
  fetch_word_t wr_word, head;

  // Ready only looks at registered state, so there is no out_ready->in_ready path.
  assign in_ready  = (count != FULL) | (state == ST_SHADOW);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign store     = push & (state == ST_RUN) & ~flush;
  assign take      = pop & ~flush;

  assign wr_word.pc    = in_pc;
  assign wr_word.instr = in_instr;

  if_id_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (store),
    .rd_en   (take),
    .wr_data (wr_word),
    .rd_data (head),
    .count   (count)
  );

  assign out_instr = out_valid ? head.instr : NOP_WORD;
  assign out_pc    = out_valid ? head.pc    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      shadow_cnt <= '0;
    end else begin
      state      <= state_next;
      shadow_cnt <= shadow_next;
    end
  end

  // Flush (re)arms the shadow; each accepted word in the shadow burns one slot.
  always_comb begin
    state_next  = state;
    shadow_next = shadow_cnt;
    if (flush) begin
      if (SHADOW > 0) begin
        state_next  = ST_SHADOW;
        shadow_next = SHADOW_LOAD;
      end else begin
        state_next  = ST_RUN;
        shadow_next = '0;
      end
    end else if (state == ST_SHADOW && push) begin
      shadow_next = shadow_cnt - 2'd1;
      if (shadow_cnt == 2'd1) state_next = ST_RUN;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] drop_add;

  always_comb begin
    drop_add = 32'd0;
    if (flush)                            drop_add = 32'(count);
    else if (state == ST_SHADOW && push)  drop_add = 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      flushed_words <= '0;
    end else begin
      stall_cycles  <= sat_add(stall_cycles, {31'b0, in_valid & ~in_ready});
      flushed_words <= sat_add(flushed_words, drop_add);
    end
  end
`else
  // Perf counters compiled out: no extra ports or state.
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed table, flush sequences, random vs queue model.
module tb_if_id_buffer;

  localparam int DEPTH  = 2;
  localparam int SHADOW = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushed_words;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: queue of {pc, instr}, shadow flag and words left to drop
  logic [63:0] mq[$];
  bit          m_shadow;
  int          m_left;
  longint      m_stall;
  longint      m_flushed;

  always #5 clk = ~clk;

  if_id_buffer #(
    .DEPTH(DEPTH),
    .SHADOW(SHADOW),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flushed_words (flushed_words)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_count;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_shadow  = 0;
    m_left    = 0;
    m_stall   = 0;
    m_flushed = 0;
  endtask

  task automatic checkOutput();
    logic [63:0] head;
    bit          nonempty;
    nonempty = (mq.size() != 0);
    head     = nonempty ? mq[0] : 64'h0;
    check("out_valid", 64'(out_valid), 64'(nonempty));
    check("out_instr", 64'(out_instr), nonempty ? 64'(head[31:0]) : 64'h0);
    check("out_pc",    64'(out_pc),    nonempty ? 64'(head[63:32]) : 64'h0);
    check("count",     64'(count),     64'(mq.size()));
    check("in_ready",  64'(in_ready),  64'((mq.size() != DEPTH) || m_shadow));
`ifdef IF_ID_PERF_EN
    check("stall_cycles",  64'(stall_cycles),  64'(m_stall));
    check("flushed_words", 64'(flushed_words), 64'(m_flushed));
`endif
  endtask

  // Drive one cycle, check pre-edge outputs, advance the model at the edge
  task automatic applyStimulus(input logic iv, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    bit rdy, psh, pp;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    rdy = (mq.size() != DEPTH) || m_shadow;
    psh = iv && rdy;
    pp  = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (iv && !rdy) m_stall++;
    if (fl) begin
      m_flushed += mq.size();
      mq.delete();
      m_shadow = (SHADOW > 0);
      m_left   = SHADOW;
    end else begin
      if (pp) void'(mq.pop_front());
      if (psh) begin
        if (m_shadow) begin
          m_flushed++;
          m_left--;
          if (m_left == 0) m_shadow = 0;
        end else begin
          mq.push_back({pc, mk_instr(pc)});
        end
      end
    end
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    model_clear();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_clear();

    vecs[0] = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1, 1'b1};
    vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h04, 1, 1'b1};
    vecs[2] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 1, 1'b1};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1};
    vecs[4] = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1};
    vecs[5] = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h00, 2, 1'b0};
    vecs[6] = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 32'h00, 2, 1'b0};
    vecs[7] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h04, 1, 1'b1};
    vecs[8] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 1, 1'b1};
    vecs[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1};

    repeat (2) @(posedge clk);
    #2;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput();

    $display("[TB] streaming and backpressure table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vecs[i].e_pc));
      check($sformatf("vec%0d_count", i), 64'(count),     64'(vecs[i].e_count));
      check($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].e_rdy));
    end

    $display("[TB] flush with shadow drop");
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_shadow_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    check("shadow_drop_count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    check("post_shadow_count", 64'(count), 64'd1);
    check("post_shadow_pc", 64'(out_pc), 64'h40);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] flush during shadow reloads");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b0);
    check("reload_drop_count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h54, 1'b0, 1'b0);
    check("reload_keep_pc", 64'(out_pc), 64'h54);
    applyStimulus(1'b1, 32'h58, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5C, 1'b1, 1'b0);
    check("full_pushpop_head", 64'(out_pc), 64'h58);
    applyStimulus(1'b1, 32'h5C, 1'b1, 1'b0);
    check("order_after_full", 64'(out_pc), 64'h5C);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef IF_ID_PERF_EN
    $display("[TB] perf counters");
    doReset();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    check("perf_stall", 64'(stall_cycles), 64'd3);
    check("perf_flushed", 64'(flushed_words), 64'd3);
`endif

    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    doReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, {$urandom_range(0, 32'hFFFF), 2'b00},
                    ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    #1;
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
